// File: rtl/nonpu_pkg.sv
// Shared constants for the spike raster: display modes, pixel limits and the
// default grey bias.
package nonpu_pkg;

    typedef enum logic {
        MODE_GREY  = 1'b0,
        MODE_SPIKE = 1'b1
    } mode_e;

    localparam logic [7:0] PIX_MAX      = 8'd255;
    localparam logic [7:0] PIX_MIN      = 8'd0;
    localparam logic [7:0] DEFAULT_BIAS = 8'd128;

endpackage

// File: rtl/spike_raster_fifo.sv
// Synchronous FIFO with a registered head entry; the head is refilled from the
// ring one edge after an entry lands there.
module spike_raster_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    mem_cnt;
    logic              load;

    // Head and ring together never exceed DEPTH entries.
    assign load  = (mem_cnt != '0) && (!head_valid || pop);
    assign full  = (mem_cnt + {{PTR_W{1'b0}}, head_valid}) == (PTR_W+1)'(DEPTH);
    assign empty = !head_valid && (mem_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + (PTR_W+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (PTR_W+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (load) begin
                head_valid <= 1'b1;
                head       <= mem[rd_ptr];
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spike_raster.sv
// Multi-channel neuron event rasteriser: per-channel holding registers, a
// round-robin arbiter, voltage-to-grey conversion and an output FIFO toward a
// framebuffer. Optional event counters are built with SPIKE_RASTER_STATS_EN.
module spike_raster
    import nonpu_pkg::*;
#(
    parameter int WIDTH             = 32,
    parameter int FRAC              = 16,
    parameter int NEURON_ADDR_WIDTH = 8,
    parameter int NUM_CH            = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH-1:0]                         in_valid,
    output logic [NUM_CH-1:0]                         in_ready,
    input  logic [NUM_CH-1:0]                         in_spike,
    input  logic [NUM_CH*NEURON_ADDR_WIDTH-1:0]       in_idx,
    input  logic [NUM_CH*WIDTH-1:0]                   in_v,
    input  logic [4:0]                                cfg_shift,
    input  logic [7:0]                                cfg_bias,
    input  logic                                      cfg_mode,
    output logic                                      fb_we,
    input  logic                                      fb_ready,
    output logic [$clog2(NUM_CH)+NEURON_ADDR_WIDTH-1:0] fb_addr,
    output logic [7:0]                                fb_data,
    output logic                                      busy
`ifdef SPIKE_RASTER_STATS_EN
    ,
    input  logic                                      stat_clear,
    output logic [31:0]                               stat_spikes,
    output logic [31:0]                               stat_discards
`endif
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int NAW     = NEURON_ADDR_WIDTH;
    localparam int ADDR_W  = CH_W + NAW;
    localparam int ENTRY_W = 8 + ADDR_W;

    if (NUM_CH < 2 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_chk_ch
        $error("NUM_CH must be a power of two, at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (WIDTH <= 8 || FRAC < 0 || FRAC >= WIDTH) begin : g_chk_width
        $error("WIDTH must exceed 8 and FRAC must lie within WIDTH");
    end

    // Full-width signed result in, pixel out; clamps before any truncation.
    function automatic logic [7:0] sat_pixel(input logic signed [WIDTH:0] g);
        if (g[WIDTH]) return PIX_MIN;
        if (|g[WIDTH-1:8]) return PIX_MAX;
        return g[7:0];
    endfunction

    // Stage p0: per-channel holding registers.
    logic [NUM_CH-1:0]      vld_p0;
    logic [NUM_CH-1:0]      spike_p0;
    logic [NAW-1:0]         idx_p0 [NUM_CH];
    logic signed [WIDTH-1:0] v_p0  [NUM_CH];

    logic [CH_W-1:0]        rr_ptr;
    logic [CH_W-1:0]        sel;
    logic [CH_W-1:0]        cand;
    logic                   found;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   grant_any;
    logic [NUM_CH-1:0]      grant;
    logic                   push;
    logic                   discard;
    logic signed [WIDTH-1:0] shifted;
    logic signed [WIDTH:0]  grey;
    logic [7:0]             pixel;
    logic [ENTRY_W-1:0]     entry;
    logic [ENTRY_W-1:0]     head;
    logic [NUM_CH-1:0]      accept;

    assign pop      = fb_we && fb_ready;
    assign in_ready = rst ? '0 : (~vld_p0 | grant);
    assign accept   = in_valid & in_ready;

    // Descending scan so the occupied channel nearest the pointer wins.
    always_comb begin
        sel   = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = rr_ptr + CH_W'(i);
            if (vld_p0[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any  = found && (!fifo_full || pop) && !rst;
        grant      = '0;
        grant[sel] = grant_any;
        shifted    = v_p0[sel] >>> cfg_shift;
        grey       = {shifted[WIDTH-1], shifted} + $signed({{(WIDTH-7){1'b0}}, cfg_bias});
        pixel      = spike_p0[sel] ? PIX_MAX : sat_pixel(grey);
        push       = grant_any && (spike_p0[sel] || mode_e'(cfg_mode) == MODE_GREY);
        discard    = grant_any && !spike_p0[sel] && mode_e'(cfg_mode) == MODE_SPIKE;
        entry      = {pixel, sel, idx_p0[sel]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= '0;
            rr_ptr <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) vld_p0[c] <= 1'b1;
                else if (grant[c]) vld_p0[c] <= 1'b0;
            end
            if (grant_any) rr_ptr <= sel + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) begin
                spike_p0[c] <= in_spike[c];
                idx_p0[c]   <= in_idx[c*NAW +: NAW];
                v_p0[c]     <= in_v[c*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p1: FIFO toward the framebuffer.
    spike_raster_fifo #(
        .DATA_W(ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (entry),
        .pop       (pop),
        .head_valid(fb_we),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fb_addr = head[ADDR_W-1:0];
    assign fb_data = head[ENTRY_W-1:ADDR_W];
    assign busy    = (|vld_p0) || !fifo_empty;

`ifdef SPIKE_RASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            stat_spikes   <= '0;
            stat_discards <= '0;
        end else begin
            if (push && spike_p0[sel] && !(&stat_spikes)) stat_spikes <= stat_spikes + 32'd1;
            if (discard && !(&stat_discards)) stat_discards <= stat_discards + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spike_raster.sv
// Randomised and directed bench for spike_raster against a per-channel
// queue reference model. Build with SPIKE_RASTER_STATS_EN to cover the counters.
module tb_spike_raster;
    import nonpu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int NAW    = 8;
    localparam int NUM_CH = 4;
    localparam int AW     = 2 + NAW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH-1:0]       in_spike;
    logic [NUM_CH*NAW-1:0]   in_idx;
    logic [NUM_CH*WIDTH-1:0] in_v;
    logic [4:0]              cfg_shift;
    logic [7:0]              cfg_bias;
    logic                    cfg_mode;
    logic                    fb_we;
    logic                    fb_ready;
    logic [AW-1:0]           fb_addr;
    logic [7:0]              fb_data;
    logic                    busy;
`ifdef SPIKE_RASTER_STATS_EN
    logic                    stat_clear;
    logic [31:0]             stat_spikes;
    logic [31:0]             stat_discards;
`endif

    spike_raster dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_spike (in_spike),
        .in_idx   (in_idx),
        .in_v     (in_v),
        .cfg_shift(cfg_shift),
        .cfg_bias (cfg_bias),
        .cfg_mode (cfg_mode),
        .fb_we    (fb_we),
        .fb_ready (fb_ready),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .busy     (busy)
`ifdef SPIKE_RASTER_STATS_EN
        ,
        .stat_clear   (stat_clear),
        .stat_spikes  (stat_spikes),
        .stat_discards(stat_discards)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    pix;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp_q [NUM_CH][$];
    int            wr_ch [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_wr  = 0;
    logic [NUM_CH-1:0] acc;
    logic [7:0]    last_data;
    logic          stall_prev;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grey value from the rule: floor(v / 2^shift) + bias, clamped to a byte.
    function automatic logic [7:0] ref_pix(input logic [31:0] v, input logic sp,
                                           input int shift, input int bias);
        longint val, dv, q, g;
        if (sp) return 8'd255;
        val = longint'($signed(v));
        dv  = longint'(1) << shift;
        q   = val / dv;
        if (val < 0 && q * dv != val) q = q - 1;
        g = q + longint'(bias);
        if (g < 0) return 8'd0;
        if (g > 255) return 8'd255;
        return 8'(g);
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
        return n;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    endtask

    // Observe at the falling edge, then return just after the next rising edge.
    task automatic tick();
        exp_t e;
        int   ch;
        @(negedge clk);
        acc = '0;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    acc[c] = 1'b1;
                    n_acc++;
                    if (in_spike[c] || cfg_mode == 1'b0) begin
                        e.pix  = ref_pix(in_v[c*WIDTH +: WIDTH], in_spike[c], int'(cfg_shift), int'(cfg_bias));
                        e.addr = {2'(c), in_idx[c*NAW +: NAW]};
                        exp_q[c].push_back(e);
                    end
                end
            end
            if (stall_prev) begin
                chk("stall_we", fb_we, 1);
                chk("stall_addr", fb_addr, prev_addr);
                chk("stall_data", fb_data, prev_data);
            end
            stall_prev = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
            if (fb_we && fb_ready) begin
                ch = int'(fb_addr[AW-1:NAW]);
                n_wr++;
                wr_ch.push_back(ch);
                last_data = fb_data;
                chk("wr_expected", exp_q[ch].size() != 0, 1);
                if (exp_q[ch].size() != 0) begin
                    e = exp_q[ch].pop_front();
                    chk("wr_addr", fb_addr, e.addr);
                    chk("wr_data", fb_data, e.pix);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int c, input logic [7:0] idx, input logic [31:0] v, input logic sp);
        in_valid[c]              = 1'b1;
        in_spike[c]              = sp;
        in_idx[c*NAW +: NAW]     = idx;
        in_v[c*WIDTH +: WIDTH]   = v;
    endtask

    task automatic send(input int c, input logic [7:0] idx, input logic [31:0] v, input logic sp);
        offer(c, idx, v, sp);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc[c]) break;
        end
        chk("send_accepted", acc[c], 1);
        in_valid[c] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        in_valid = '0;
        while ((busy || pending() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_model", pending(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '0;
        tick();
        tick();
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        clear_model();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 4'hF);
    endtask

    function automatic logic [31:0] rand_v(input int shift);
        int base;
        base = int'($urandom_range(0, 1023)) - 512;
        return 32'(base <<< shift) | ($urandom & ((32'd1 << shift) - 32'd1));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        in_valid   = '0;
        in_spike   = '0;
        in_idx     = '0;
        in_v       = '0;
        cfg_shift  = 5'd12;
        cfg_bias   = DEFAULT_BIAS;
        cfg_mode   = 1'b0;
        fb_ready   = 1'b1;
        stall_prev = 1'b0;
        acc        = '0;
        last_data  = '0;
        prev_addr  = '0;
        prev_data  = '0;
`ifdef SPIKE_RASTER_STATS_EN
        stat_clear = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Latency and basic conversion
        offer(1, 8'd5, 32'h0001_0000, 1'b0);
        tick();
        chk("lat_acc", acc[1], 1);
        in_valid = '0;
        chk("lat_we_e0", fb_we, 0);
        tick();
        chk("lat_we_e1", fb_we, 0);
        tick();
        chk("lat_we_e2", fb_we, 1);
        chk("lat_addr", fb_addr, {2'd1, 8'd5});
        chk("lat_data", fb_data, 144);
        drain(20);

        // Saturation at full width
        send(2, 8'd9, 32'hFFF0_0000, 1'b0);
        drain(20);
        chk("sat_low", last_data, 0);
        send(3, 8'd10, 32'h0064_0000, 1'b0);
        drain(20);
        chk("sat_high", last_data, 255);

        // Round robin from a fresh pointer, then resume after the last grant
        do_reset();
        wr_ch.delete();
        for (int c = 0; c < NUM_CH; c++) offer(c, 8'(16 + c), rand_v(12), 1'b0);
        tick();
        chk("rr_all_acc", acc, 4'hF);
        drain(40);
        chk("rr_count", wr_ch.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", wr_ch[i], i);
        send(1, 8'd30, rand_v(12), 1'b0);
        drain(20);
        wr_ch.delete();
        for (int c = 0; c < NUM_CH; c++) offer(c, 8'(40 + c), rand_v(12), 1'b0);
        tick();
        drain(40);
        chk("rr2_count", wr_ch.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_resume", wr_ch[i], (i + 2) % 4);

        // Backpressure: FIFO plus holding registers absorb exactly 12 events
        fb_ready = 1'b0;
        n0 = n_acc;
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < NUM_CH; c++)
                if (!in_valid[c] || acc[c]) offer(c, 8'($urandom), rand_v(12), 1'($urandom_range(0, 1)));
            tick();
        end
        chk("stall_accepts", n_acc - n0, 12);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_busy", busy, 1);
        in_valid = '0;
        fb_ready = 1'b1;
        drain(60);

        // Spike-only mode
        cfg_mode = MODE_SPIKE;
`ifdef SPIKE_RASTER_STATS_EN
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
`endif
        n0 = n_wr;
        send(0, 8'd1, rand_v(12), 1'b1);
        send(1, 8'd2, rand_v(12), 1'b0);
        send(2, 8'd3, rand_v(12), 1'b0);
        send(3, 8'd4, rand_v(12), 1'b1);
        send(0, 8'd5, rand_v(12), 1'b0);
        send(1, 8'd6, rand_v(12), 1'b0);
        send(2, 8'd7, rand_v(12), 1'b1);
        send(3, 8'd8, rand_v(12), 1'b0);
        drain(40);
        chk("m1_writes", n_wr - n0, 3);
        chk("m1_last", last_data, 255);
`ifdef SPIKE_RASTER_STATS_EN
        chk("stat_spikes", stat_spikes, 3);
        chk("stat_discards", stat_discards, 5);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        chk("stat_clear_sp", stat_spikes, 0);
        chk("stat_clear_dc", stat_discards, 0);
`endif
        cfg_mode = MODE_GREY;

        // Reset with three FIFO entries and two held events
        do_reset();
        fb_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) offer(c, 8'(60 + c), rand_v(12), 1'b0);
        tick();
        in_valid = '0;
        offer(0, 8'd70, rand_v(12), 1'b0);
        tick();
        chk("mid_refill", acc[0], 1);
        in_valid = '0;
        tick();
        tick();
        chk("mid_busy", busy, 1);
        chk("mid_we", fb_we, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_we", fb_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        rst = 1'b0;
        clear_model();
        fb_ready = 1'b1;
        n0 = n_wr;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_no_stale", n_wr - n0, 0);
        send(2, 8'd77, 32'h0001_0000, 1'b0);
        drain(20);
        chk("mid_fresh", last_data, 144);

        // Randomised traffic against the reference model
        for (int ph = 0; ph < 3; ph++) begin
            cfg_shift = 5'($urandom_range(4, 20));
            cfg_bias  = 8'($urandom);
            cfg_mode  = (ph == 2);
            acc = '0;
            for (int k = 0; k < 300; k++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!in_valid[c] || acc[c]) begin
                        if ($urandom_range(0, 3) != 0)
                            offer(c, 8'($urandom), rand_v(int'(cfg_shift)), 1'($urandom_range(0, 3) == 0));
                        else
                            in_valid[c] = 1'b0;
                    end
                end
                fb_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            in_valid = '0;
            fb_ready = 1'b1;
            drain(200);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spike_raster.md
SPIKE_RASTER -- requirements
Module: spike_raster

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, membrane voltage width, signed fixed point.
- FRAC, 16, fractional bits of v.
- NEURON_ADDR_WIDTH, 8, neuron index width per channel.
- NUM_CH, 4, input channels, power of two, at least 2.
- FIFO_DEPTH, 8, output FIFO entries, power of two, at least 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, NUM_CH, per-channel event valid.
- in_ready, out, NUM_CH, per-channel accept.
- in_spike, in, NUM_CH, event is a spike.
- in_idx, in, NUM_CH*NEURON_ADDR_WIDTH, packed neuron index; channel c occupies slice c.
- in_v, in, NUM_CH*WIDTH, packed signed voltage.
- cfg_shift, in, 5, arithmetic right shift applied to v.
- cfg_bias, in, 8, unsigned gray bias (128 gives mid-grey at v=0).
- cfg_mode, in, 1, 0 = grey, 1 = spike-only.
- fb_we, out, 1, framebuffer write valid.
- fb_ready, in, 1, framebuffer accepts.
- fb_addr, out, log2(NUM_CH)+NEURON_ADDR_WIDTH, {channel, neuron_idx}.
- fb_data, out, 8, pixel.
- busy, out, 1, any holding register or FIFO entry occupied.

Function
REQ-003 Each channel SHALL have a one-entry holding register; in_ready[c] = !hold_valid[c] || grant[c].
REQ-004 An event SHALL be accepted on a rising edge where in_valid[c] && in_ready[c]; in_spike, in_idx and in_v SHALL be captured at that edge.
REQ-005 The round-robin arbiter SHALL grant at most one occupied holding register per cycle.
- Search starts at the channel after the last grant.
- After reset, search starts at channel 0.
REQ-006 A grant SHALL occur only if the FIFO is not full or a pop occurs in the same cycle.
REQ-007 Conversion SHALL be combinational on the granted entry.
- s = v >>> cfg_shift, sign-extended at full WIDTH.
- g = s + cfg_bias, computed at WIDTH+1 bits.
- Pixel = 0 if g<0, 255 if g>255, else g[7:0].
- No truncation before saturation.
REQ-008 A spike SHALL produce pixel 255 in both modes.
REQ-009 In mode 1, a granted non-spike SHALL be consumed and discarded, with no FIFO push.
REQ-010 A grant with a push SHALL write {pixel, channel, idx} into the FIFO on the same edge.
REQ-011 fb_we SHALL equal FIFO not-empty; fb_addr/fb_data SHALL present the head entry.
REQ-012 The head entry SHALL pop on a rising edge where fb_we && fb_ready.
REQ-013 fb_we, fb_addr and fb_data SHALL remain stable while fb_we && !fb_ready.
REQ-014 Latency SHALL be 2 edges from acceptance to fb_we high when the FIFO is empty and no other channel is contending.
REQ-015 Simultaneous push and pop on a full FIFO SHALL keep the count unchanged and lose no data.
REQ-016 FIFO order SHALL equal grant order; per-channel event order SHALL be preserved.
REQ-017 cfg_* changes SHALL take effect at the next grant; entries already in the FIFO are unaffected.

Reset
REQ-018 While rst is high on an edge:
- All holding valids cleared, FIFO emptied, arbiter pointer set to channel 0.
- fb_we=0, fb_addr=0, fb_data=0, busy=0, in_ready all 0.
REQ-019 Reset mid-operation SHALL discard pending events without emitting a partial write.
REQ-020 The first acceptance after reset SHALL be possible on the edge following rst deassertion.

Configuration
REQ-021 With macro SPIKE_RASTER_STATS_EN defined, the block SHALL add:
- stat_clear, in, 1.
- stat_spikes, out, 32: spike pushes.
- stat_discards, out, 32: mode-1 discards.
- Both counters saturate at all-ones.
- Both counters are cleared by rst or stat_clear; clear wins over a same-cycle increment.
REQ-022 Without the macro, these ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-023 Package nonpu_pkg SHALL hold:
- Mode constants MODE_GREY=0 and MODE_SPIKE=1.
- Constants PIX_MAX=255 and PIX_MIN=0.
- Default bias 128.
REQ-024 The FIFO SHALL be sub-module spike_raster_fifo (synchronous, registered head, full/empty flags); arbitration and conversion SHALL stay in spike_raster.

Verification
REQ-025 Directed scenarios the bench SHALL cover (FRAC=16, cfg_shift=12, cfg_bias=128, mode 0, fb_ready=1, unless stated):
- v=0x00010000 on ch1 idx 5, no spike -> fb_addr={1,5}, fb_data=144, fb_we high 2 edges after acceptance.
- v=0xFFF00000 -> fb_data=0; v=0x00640000 -> fb_data=255, proving full-width saturation.
- All 4 channels valid in the same cycle with FIFO empty -> writes emitted in channel order 0,1,2,3; next round resumes at the channel after the last grant.
- fb_ready held low for 20 cycles with continuous input -> FIFO fills to 8; in_ready drops once holding registers fill; no loss or duplication after release; fb outputs stable while stalled.
- Mode 1 with a mix of 3 spikes and 5 non-spikes -> exactly 3 writes of 255; with SPIKE_RASTER_STATS_EN, stat_spikes=3 and stat_discards=5.
- rst asserted with 3 FIFO entries and 2 held events -> fb_we=0 on the next edge, busy=0, and no stale writes after release.
